// File: rtl/y86_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : y86_pipe_ctrl
// Brief    : Y86 5-stage pipeline control: hazards, memory-wait timeout,
//            halt latch and architectural condition codes.
//            Optional performance counters under PIPE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module y86_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic             e_zf,
    input  logic             e_sf,
    input  logic             e_of,
    input  logic [3:0]       M_icode,
    input  logic             m_stat_err,
    input  logic             W_stat_err,
    input  logic             dmem_ready,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             mem_err,
    output logic             halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_bubbles
`endif
);

    localparam logic [3:0] c_IOPL    = 4'h6;
    localparam logic [3:0] c_IRMMOVL = 4'h4;
    localparam logic [3:0] c_IMRMOVL = 4'h5;
    localparam logic [3:0] c_IJXX    = 4'h7;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHL  = 4'hA;
    localparam logic [3:0] c_IPOPL   = 4'hB;
    localparam logic [3:0] c_RNONE   = 4'hF;
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t     r_state_q, w_state_d;
    logic [7:0] r_wait_cnt_q, w_wait_cnt_d;
    logic       r_mem_err_q, w_mem_err_d;
    logic [2:0] r_cc_q, w_cc_d;

    logic w_load_use, w_lu, w_mispred, w_ret, w_memop, w_mem_wait, w_hold;

    always_comb begin
        w_load_use = (E_icode == c_IMRMOVL || E_icode == c_IPOPL) && (E_dstM != c_RNONE)
                     && (E_dstM == d_srcA || E_dstM == d_srcB);
        w_mispred  = (E_icode == c_IJXX) && !e_Cnd;
        w_lu       = w_load_use && !w_mispred;
        w_ret      = (D_icode == c_IRET) || (E_icode == c_IRET) || (M_icode == c_IRET);
        w_memop    = (M_icode == c_IRMMOVL) || (M_icode == c_IMRMOVL) || (M_icode == c_ICALL)
                     || (M_icode == c_IRET) || (M_icode == c_IPUSHL) || (M_icode == c_IPOPL);
        w_mem_wait = w_memop && !dmem_ready && (r_state_q == ST_RUN);
        w_hold     = w_mem_wait || (r_state_q == ST_MEM_WAIT && !dmem_ready);
    end

    // Priority: reset forces bubbles, then halt freezes, then memory wait, then hazards.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        E_stall  = 1'b0;
        M_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else if (r_state_q == ST_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_stall = 1'b1;
            M_stall = 1'b1;
            W_stall = 1'b1;
        end else if (w_hold) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            F_stall  = w_lu || w_ret;
            D_stall  = w_lu;
            D_bubble = w_mispred || (w_ret && !w_lu);
            E_bubble = w_mispred || w_lu;
            M_bubble = m_stat_err || W_stat_err;
            W_stall  = W_stat_err;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_wait_cnt_d = 8'd0;
        w_mem_err_d  = r_mem_err_q;
        w_cc_d       = r_cc_q;
        case (r_state_q)
            ST_RUN: begin
                if (w_mem_wait) w_state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                w_wait_cnt_d = r_wait_cnt_q + 8'd1;
                if (dmem_ready) begin
                    w_state_d = ST_RUN;
                end else if (r_wait_cnt_q == c_WAIT_LAST) begin
                    w_state_d   = ST_HALTED;
                    w_mem_err_d = 1'b1;
                end
            end
            default: w_state_d = ST_HALTED;
        endcase
        if (W_stat_err) w_state_d = ST_HALTED;
        if (E_icode == c_IOPL && !m_stat_err && !W_stat_err && !E_stall
            && r_state_q != ST_HALTED) begin
            w_cc_d = {e_zf, e_sf, e_of};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= ST_RUN;
            r_wait_cnt_q <= 8'd0;
            r_mem_err_q  <= 1'b0;
            r_cc_q       <= 3'b100;
        end else begin
            r_state_q    <= w_state_d;
            r_wait_cnt_q <= w_wait_cnt_d;
            r_mem_err_q  <= w_mem_err_d;
            r_cc_q       <= w_cc_d;
        end
    end

    assign cc_zf   = r_cc_q[2];
    assign cc_sf   = r_cc_q[1];
    assign cc_of   = r_cc_q[0];
    assign mem_err = r_mem_err_q;
    assign halted  = (r_state_q == ST_HALTED);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_cycles_q, r_perf_stalls_q, r_perf_bubbles_q;
    logic [CNT_W-1:0] w_perf_cycles_d, w_perf_stalls_d, w_perf_bubbles_d;

    always_comb begin
        w_perf_cycles_d  = r_perf_cycles_q;
        w_perf_stalls_d  = r_perf_stalls_q;
        w_perf_bubbles_d = r_perf_bubbles_q;
        if (r_state_q != ST_HALTED) begin
            w_perf_cycles_d = r_perf_cycles_q + 1'b1;
            if (F_stall)              w_perf_stalls_d  = r_perf_stalls_q + 1'b1;
            if (D_bubble || E_bubble) w_perf_bubbles_d = r_perf_bubbles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles_q  <= '0;
            r_perf_stalls_q  <= '0;
            r_perf_bubbles_q <= '0;
        end else begin
            r_perf_cycles_q  <= w_perf_cycles_d;
            r_perf_stalls_q  <= w_perf_stalls_d;
            r_perf_bubbles_q <= w_perf_bubbles_d;
        end
    end

    assign perf_cycles  = r_perf_cycles_q;
    assign perf_stalls  = r_perf_stalls_q;
    assign perf_bubbles = r_perf_bubbles_q;
`endif

endmodule
`default_nettype wire
